// File: rtl/serial_shift_transmitter.sv
// Serial frame transmitter (mode 0): shifts a DATA_WIDTH word out on mosi, using an
// external divided clock (sampled as data) to pace sclk, with cs_n framing and a done pulse.
module serial_shift_transmitter #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  div_clk,
  output logic                  div_enable,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs_n,
  output logic                  done
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t                state, state_nxt;
  logic                  div_clk_d;
  logic                  rise, fall;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_count;
  logic                  load, shift_en, count_en, end_frame;
  logic                  first_bit, next_bit;
  logic [DATA_WIDTH-1:0] shreg_shifted;

  assign rise = div_clk & ~div_clk_d;
  assign fall = ~div_clk & div_clk_d;

  // done holds off ready for one cycle so cs_n always has a high gap between frames
  assign tx_ready = (state == IDLE) & ~done & ~rst;
  assign sclk     = (state != IDLE) & div_clk;

  assign first_bit     = MSB_FIRST ? tx_data[DATA_WIDTH-1] : tx_data[0];
  assign next_bit      = MSB_FIRST ? shreg[DATA_WIDTH-2]   : shreg[1];
  assign shreg_shifted = MSB_FIRST ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg[DATA_WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift_en  = 1'b0;
    count_en  = 1'b0;
    end_frame = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          count_en = 1'b1;
          if (bit_count == CW'(DATA_WIDTH - 1)) state_nxt = FINISH;
        end else if (fall && (bit_count < CW'(DATA_WIDTH))) begin
          shift_en = 1'b1;
        end
      end
      FINISH: begin
        if (fall) begin
          end_frame = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_clk_d  <= 1'b0;
      shreg      <= '0;
      bit_count  <= '0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      div_enable <= 1'b0;
      done       <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_clk_d <= div_clk;
      done      <= end_frame;
      if (load) begin
        shreg      <= tx_data;
        mosi       <= first_bit;
        cs_n       <= 1'b0;
        div_enable <= 1'b1;
        bit_count  <= '0;
      end
      if (shift_en) begin
        shreg <= shreg_shifted;
        mosi  <= next_bit;
      end
      if (count_en) bit_count <= bit_count + 1'b1;
      if (end_frame) begin
        div_enable <= 1'b0;
        cs_n       <= 1'b1;
        mosi       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_serial_shift_transmitter.sv
// Bench for serial_shift_transmitter: MSB-first (inst 0) and LSB-first (inst 1) copies,
// each fed by a divider model that toggles every 4 clk cycles while enabled.
module tb_serial_shift_transmitter;
  logic       clk;
  logic       rst       [2];
  logic [7:0] tx_data   [2];
  logic       tx_valid  [2];
  logic       tx_ready  [2];
  logic       div_clk   [2];
  logic       div_en    [2];
  logic       sclk      [2];
  logic       mosi      [2];
  logic       cs_n      [2];
  logic       done      [2];
  logic       force_hi  [2];
  int         dcnt      [2];

  int         rises     [2];
  int         done_cnt  [2];
  int         ready_bad [2];
  int         rise_cs_bad [2];
  int         done_cs_bad [2];
  int         hi_run    [2];
  int         last_gap  [2];
  logic       sclk_p    [2];
  logic       cs_p      [2];
  logic [7:0] cap       [2];

  int n_vec = 0;
  int n_err = 0;

  serial_shift_transmitter #(.DATA_WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .div_clk(div_clk[0]), .div_enable(div_en[0]),
    .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .done(done[0]));

  serial_shift_transmitter #(.DATA_WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .div_clk(div_clk[1]), .div_enable(div_en[1]),
    .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .done(done[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider model
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (force_hi[i]) div_clk[i] <= 1'b1;
      else if (!div_en[i]) begin
        div_clk[i] <= 1'b0;
        dcnt[i]    <= 0;
      end else if (dcnt[i] == 3) begin
        dcnt[i]    <= 0;
        div_clk[i] <= ~div_clk[i];
      end else dcnt[i] <= dcnt[i] + 1;
    end
  end

  // receiver / protocol monitor, sampled mid-cycle
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk[i] === 1'b1 && sclk_p[i] === 1'b0) begin
        rises[i]++;
        cap[i] = {cap[i][6:0], mosi[i]};
        if (cs_n[i] !== 1'b0) rise_cs_bad[i]++;
      end
      if (done[i] === 1'b1) begin
        done_cnt[i]++;
        if (cs_n[i] !== 1'b1) done_cs_bad[i]++;
      end
      if (cs_n[i] === 1'b0 && tx_ready[i] !== 1'b0) ready_bad[i]++;
      if (cs_n[i] === 1'b1) hi_run[i]++;
      else begin
        if (cs_p[i] === 1'b1) last_gap[i] = hi_run[i];
        hi_run[i] = 0;
      end
      sclk_p[i] = sclk[i];
      cs_p[i]   = cs_n[i];
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // expected receiver sample order, first sample in bit 7
  function automatic logic [7:0] model_bits(input int s, input logic [7:0] w);
    logic [7:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r = {r[6:0], (s == 0) ? w[7-k] : w[k]};
    return r;
  endfunction

  task automatic wait_ready(input int s);
    int t = 0;
    while (tx_ready[s] !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("ready_timeout", 32'(t < 100), 1);
  endtask

  task automatic wait_done(input int s);
    int t = 0;
    while (done[s] !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    check("done_timeout", 32'(t < 1000), 1);
  endtask

  task automatic send(input int s, input logic [7:0] w, input logic [7:0] exp_bits,
                      input bit scramble);
    int r0, d0, rb0, cb0, db0;
    wait_ready(s);
    r0 = rises[s]; d0 = done_cnt[s]; rb0 = ready_bad[s];
    cb0 = rise_cs_bad[s]; db0 = done_cs_bad[s];
    tx_data[s] = w; tx_valid[s] = 1'b1;
    @(negedge clk);
    tx_valid[s] = 1'b0;
    if (scramble) tx_data[s] = ~w;
    wait_done(s);
    @(negedge clk); @(negedge clk);
    check("sclk_rises", 32'(rises[s] - r0), 8);
    check("mosi_bits", 32'(cap[s]), 32'(exp_bits));
    check("done_pulses", 32'(done_cnt[s] - d0), 1);
    check("done_cs_high", 32'(done_cs_bad[s] - db0), 0);
    check("cs_low_at_rise", 32'(rise_cs_bad[s] - cb0), 0);
    check("ready_low_busy", 32'(ready_bad[s] - rb0), 0);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [7:0] bits;
    bit         scramble;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, d0, t;
    logic [7:0] w;
    int s;
    bit sc;

    tbl[0] = '{0, 8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{1, 8'hA5, 8'hA5, 1'b0};
    tbl[2] = '{0, 8'h3C, 8'h3C, 1'b0};
    tbl[3] = '{1, 8'h01, 8'h80, 1'b1};
    tbl[4] = '{1, 8'h80, 8'h01, 1'b0};
    tbl[5] = '{0, 8'h96, 8'h96, 1'b1};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; tx_data[i] = '0; tx_valid[i] = 1'b0; force_hi[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_cs_n", 32'(cs_n[i]), 1);
      check("rst_mosi", 32'(mosi[i]), 0);
      check("rst_div_en", 32'(div_en[i]), 0);
      check("rst_done", 32'(done[i]), 0);
      check("rst_sclk", 32'(sclk[i]), 0);
      check("rst_ready", 32'(tx_ready[i]), 0);
      rst[i] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("ready_after_rst", 32'(tx_ready[i]), 1);

    for (int i = 0; i < 6; i++) send(tbl[i].sel, tbl[i].data, tbl[i].bits, tbl[i].scramble);

    // back-to-back with tx_valid held high
    wait_ready(0);
    r0 = rises[0];
    tx_data[0] = 8'h3C; tx_valid[0] = 1'b1;
    @(negedge clk);
    wait_done(0);
    check("b2b_f1_rises", 32'(rises[0] - r0), 8);
    check("b2b_f1_bits", 32'(cap[0]), 32'h3C);
    tx_data[0] = 8'hC3;
    t = 0;
    while (done[0] === 1'b1 && t < 10) begin @(negedge clk); t++; end
    wait_done(0);
    tx_valid[0] = 1'b0;
    @(negedge clk);
    check("b2b_f2_rises", 32'(rises[0] - r0), 16);
    check("b2b_f2_bits", 32'(cap[0]), 32'hC3);
    check("b2b_cs_gap", 32'(last_gap[0] >= 1), 1);
    repeat (4) @(negedge clk);

    // reset after the third sclk rise aborts the frame
    wait_ready(0);
    r0 = rises[0]; d0 = done_cnt[0];
    tx_data[0] = 8'h5A; tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    t = 0;
    while (rises[0] - r0 < 3 && t < 1000) begin @(negedge clk); t++; end
    check("abort_reach_rise3", 32'(t < 1000), 1);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_cs_n", 32'(cs_n[0]), 1);
    check("abort_div_en", 32'(div_en[0]), 0);
    check("abort_mosi", 32'(mosi[0]), 0);
    check("abort_sclk", 32'(sclk[0]), 0);
    check("abort_ready", 32'(tx_ready[0]), 0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort_ready_rel", 32'(tx_ready[0]), 1);
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt[0] - d0), 0);
    send(0, 8'hFF, 8'hFF, 1'b0);

    // div_clk high while idle must not start anything
    force_hi[1] = 1'b1;
    repeat (2) @(negedge clk);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      if (sclk[1] !== 1'b0 || cs_n[1] !== 1'b1 || tx_ready[1] !== 1'b1 || div_en[1] !== 1'b0) t++;
      @(negedge clk);
    end
    check("idle_div_high", 32'(t), 0);
    force_hi[1] = 1'b0;
    repeat (3) @(negedge clk);
    send(1, 8'h5A, model_bits(1, 8'h5A), 1'b0);

    // randomized frames against the bit-order model
    for (int n = 0; n < 16; n++) begin
      s  = int'($urandom_range(0, 1));
      w  = 8'($urandom);
      sc = 1'($urandom);
      send(s, w, model_bits(s, w), sc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
